fn_unit_arbiter: RTL
====================

# fn_unit_arbiter

Two-requester round-robin arbiter and sequencer for the shared multi-cycle Gray/Binary function unit. It accepts 128-bit jobs from two upstream filter stages over valid/ready and issues one job at a time to the unit with a single-cycle enable. It waits for the unit's completion pulse, then returns the result with the requester's ID. Unsupported function codes and unit hangs are answered with an error response, so no requester ever stalls indefinitely.

## Interface
- FN_B2G, default `Bin2Gray, 3-bit function code forwarded to the unit for binary-to-Gray.
- FN_G2B, default `Gray2Bin, 3-bit function code forwarded to the unit for Gray-to-binary.
- TIMEOUT, default 255, maximum WAIT cycles before an error response; must be ≥ 130.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  job present from requester 0 / 1.
- req0_ready / req1_ready  out  1  job accepted this cycle (valid && ready).
- req0_fn / req1_fn  in  3  function code.
- req0_data / req1_data  in  128  operand.
- u_en  out  1  one-cycle enable to the unit.
- u_fn  out  3  function code to the unit; holds the registered job value.
- u_data  out  128  operand to the unit; holds the registered job value.
- u_odata  in  128  unit result.
- u_valid  in  1  unit completion pulse.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_id  out  1  requester the response belongs to.
- rsp_data  out  128  result; 0 when rsp_err=1.
- rsp_err  out  1  1 = unsupported fn or timeout.

## Operation
- FSM states and transitions:
  - IDLE: arbitrate.
    - If any reqN_valid, grant one and assert that reqN_ready combinationally in the same cycle.
    - Register fn, data and id.
    - Go to ISSUE if fn ∈ {FN_B2G, FN_G2B}; otherwise go to RESP with err=1.
  - ISSUE: u_en=1 for exactly one cycle, then WAIT. Clear the timeout counter.
  - WAIT: count cycles.
    - On u_valid=1: capture u_odata into the result register, err=0, go to RESP.
    - If the counter reaches TIMEOUT-1 without u_valid: result=0, err=1, go to RESP.
  - RESP: rsp_valid=1 with rsp_id, rsp_data, rsp_err for one cycle, then IDLE.
- Arbitration:
  - A last_grant register records the most recent winner.
  - When both requesters are valid, the requester ≠ last_grant wins.
  - With a single valid requester, that requester wins.
  - last_grant updates only on acceptance.
- At most one reqN_ready is high per cycle. Both are 0 outside IDLE.
- u_valid outside WAIT (including a late pulse after a timeout) is ignored.
- A timed-out unit is not aborted. The next job is still issued normally.
- u_fn and u_data are driven from the job registers at all times, so they are stable during and after the u_en cycle.
- Requesters must hold fn and data stable while valid && !ready.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant=1, so requester 0 wins the first contention.
  - Job, result and counter registers 0.
- Let acceptance occur in cycle A, and let L be the number of cycles from u_en to u_valid (L=129 for the Gray/Bin unit).
- Valid job:
  - u_en high in cycle A+1.
  - rsp_valid in cycle A+2+L, i.e. A+131 for the Gray/Bin unit.
- Unsupported fn: rsp_valid in cycle A+1; no u_en.
- Timeout: rsp_valid in cycle A+2+TIMEOUT.
- Throughput:
  - The next acceptance occurs no earlier than the cycle after rsp_valid.
  - Back-to-back valid jobs therefore start L+3 cycles apart.
- Reset asserted mid-job: all outputs return to 0 immediately (asynchronous) and the job is dropped with no response. A later u_valid from the unit is ignored in IDLE.

## Test plan
- **Single binary-to-Gray job:** req0, fn=FN_B2G, data=128'h5 → u_en one cycle at A+1 with u_data=128'h5. With the unit model returning 128'h7 at L=129: rsp_valid at A+131, rsp_id=0, rsp_data=128'h7, rsp_err=0.
- **Contention and round-robin:** req0 and req1 both valid continuously from reset → acceptance order 0,1,0,1. Each reqN_ready is a single-cycle pulse, and ready is never high for both requesters in the same cycle.
- **Unsupported fn:** req1, fn=3'd0 → rsp_valid at A+1 with rsp_id=1, rsp_err=1, rsp_data=0. u_en never asserted.
- **Timeout:** unit model never pulses u_valid, TIMEOUT=255 → rsp_err=1 at A+257. A late u_valid at A+300 produces no response. The next job completes normally.
- **Reset mid-WAIT:** rst pulsed during WAIT → rsp_valid never asserted for that job. Outputs read 0 during reset. After release, req0 wins a two-way contention.
- **Gray-to-binary round trip:** a Gray-to-binary job on the Bin2Gray result from the first scenario → rsp_data equals the original 128'h5.

Source files
------------

// File: rtl/fn_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle Gray/Binary function unit
// between two requesters; unsupported codes and unit hangs get an error response.
`ifndef Bin2Gray
`define Bin2Gray 3'd1
`endif
`ifndef Gray2Bin
`define Gray2Bin 3'd2
`endif

module fn_unit_arbiter #(
  parameter logic [2:0]  FN_B2G  = `Bin2Gray,
  parameter logic [2:0]  FN_G2B  = `Gray2Bin,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_fn,
  input  logic [127:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_fn,
  input  logic [127:0] req1_data,
  output logic         u_en,
  output logic [2:0]   u_fn,
  output logic [127:0] u_data,
  input  logic [127:0] u_odata,
  input  logic         u_valid,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic          last_grant, job_id, err;
  logic [2:0]    job_fn;
  logic [127:0]  job_data, result;
  logic [CW-1:0] cnt;

  logic          grant0, grant1, accept, fn_ok, timeout_hit;
  logic [2:0]    sel_fn;
  logic [127:0]  sel_data;

  // Readiness is gated by rst so no requester sees a handshake while held in reset.
  always_comb begin
    grant0      = (state == IDLE) && !rst && req0_valid && (!req1_valid || last_grant);
    grant1      = (state == IDLE) && !rst && req1_valid && (!req0_valid || !last_grant);
    accept      = grant0 || grant1;
    sel_fn      = grant1 ? req1_fn   : req0_fn;
    sel_data    = grant1 ? req1_data : req0_data;
    fn_ok       = (sel_fn == FN_B2G) || (sel_fn == FN_G2B);
    timeout_hit = (cnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = fn_ok ? ISSUE : RESP;
      ISSUE: state_nx = WAIT;
      WAIT:  if (u_valid || timeout_hit) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      job_id     <= 1'b0;
      job_fn     <= '0;
      job_data   <= '0;
      result     <= '0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          last_grant <= grant1;
          job_id     <= grant1;
          job_fn     <= sel_fn;
          job_data   <= sel_data;
          result     <= '0;
          err        <= !fn_ok;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Completion wins over a timeout landing on the same cycle.
          if (u_valid) begin
            result <= u_odata;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign u_en       = (state == ISSUE);
  assign u_fn       = job_fn;
  assign u_data     = job_data;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = rsp_valid && job_id;
  assign rsp_err    = rsp_valid && err;
  assign rsp_data   = rsp_valid ? result : '0;

endmodule
